svm_seq_pair_engine: RTL and testbench

- Sequential linear-SVM datapath: the responder to the one-vs-one DAG class picker FSM.
- Captures one feature vector, then evaluates one pairwise classifier per round using the weight/bias the picker drives.
- At the end of each round it reports the sign decision (w_class) and a one-cycle svmready strobe; the picker uses these to select the next pair.
- Repeats rounds until the picker flags the final decision (done), then returns idle for the next sample.

---
 rtl/svm_seq_pair_engine.sv | 111 +++++++++++
 tb/tb_svm_seq_pair_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_seq_pair_engine.sv
// Sequential linear-SVM datapath answering the one-vs-one DAG class picker:
// one feature vector per sample, one weight/bias dot product per round.
module svm_seq_pair_engine #(
  parameter int N_features   = 16,
  parameter int featureWidth = 4,
  parameter int weightWidth  = 8,
  parameter int biasWidth    = 12,
  parameter int biasShift    = 0,
  parameter int accWidth     = weightWidth + featureWidth + $clog2(N_features) + 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                x_valid,
  output logic                                x_ready,
  input  logic [featureWidth*N_features-1:0]  features,
  input  logic [weightWidth*N_features-1:0]   weight,
  input  logic [biasWidth-1:0]                bia,
  input  logic                                done,
  output logic                                svmready,
  output logic                                w_class,
  output logic                                busy
);

  localparam int IDX_W  = (N_features > 1) ? $clog2(N_features) : 1;
  localparam int PROD_W = weightWidth + featureWidth;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_features - 1);
  localparam logic signed [accWidth-1:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE, MAC, DECIDE, EMIT} state_t;

  state_t state, state_next;

  logic [featureWidth*N_features-1:0] feat_q;
  logic signed [accWidth-1:0]         acc;
  logic [IDX_W-1:0]                   idx;
  logic                               hold_off;
  logic                               svmready_q;
  logic                               w_class_q;

  logic signed [weightWidth-1:0] w_sel;
  logic [featureWidth-1:0]       x_sel;
  logic signed [PROD_W-1:0]      product;
  logic signed [accWidth-1:0]    product_ext;
  logic signed [accWidth-1:0]    bias_ext;
  logic signed [accWidth-1:0]    score;

  // Feature is zero-extended by one bit so the multiply stays fully signed.
  assign w_sel       = weight[int'(idx)*weightWidth +: weightWidth];
  assign x_sel       = feat_q[int'(idx)*featureWidth +: featureWidth];
  assign product     = PROD_W'(w_sel) * PROD_W'($signed({1'b0, x_sel}));
  assign product_ext = accWidth'(product);
  assign bias_ext    = accWidth'($signed(bia)) <<< biasShift;
  assign score       = acc + bias_ext;

  // hold_off keeps x_ready low for the picker's one-cycle final state.
  assign x_ready  = (state == IDLE) && !hold_off;
  assign busy     = (state != IDLE);
  assign svmready = svmready_q;
  assign w_class  = w_class_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (x_valid && x_ready) state_next = MAC;
      MAC:     if (idx == LAST_IDX) state_next = DECIDE;
      DECIDE:  state_next = EMIT;
      EMIT:    state_next = done ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      feat_q     <= '0;
      acc        <= '0;
      idx        <= '0;
      hold_off   <= 1'b0;
      svmready_q <= 1'b0;
      w_class_q  <= 1'b0;
    end else begin
      state      <= state_next;
      svmready_q <= (state == DECIDE);
      hold_off   <= (state == EMIT) && done;
      case (state)
        IDLE: begin
          if (x_valid && x_ready) begin
            feat_q <= features;
            acc    <= '0;
            idx    <= '0;
          end
        end
        MAC: begin
          acc <= acc + product_ext;
          idx <= idx + IDX_W'(1);
        end
        DECIDE: begin
          w_class_q <= (score >= ZERO);
        end
        EMIT: begin
          if (!done) begin
            acc <= '0;
            idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_seq_pair_engine.sv
// Self-checking bench for svm_seq_pair_engine: a small picker model drives
// weights/bias/done per round and decisions are checked against a dot-product model.
module tb_svm_seq_pair_engine;

  localparam int NF     = 16;
  localparam int FW     = 4;
  localparam int WW     = 8;
  localparam int BW     = 12;
  localparam int BSHIFT = 0;
  localparam int ROUND  = NF + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              x_valid;
  logic              x_ready;
  logic [FW*NF-1:0]  features;
  logic [WW*NF-1:0]  weight;
  logic [BW-1:0]     bia;
  logic              done;
  logic              svmready;
  logic              w_class;
  logic              busy;

  int cyc = 0;
  int cap_cyc = 0;
  int checks = 0;
  int errors = 0;

  svm_seq_pair_engine #(
    .N_features(NF), .featureWidth(FW), .weightWidth(WW),
    .biasWidth(BW), .biasShift(BSHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(x_ready),
    .features(features), .weight(weight), .bia(bia), .done(done),
    .svmready(svmready), .w_class(w_class), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decision score straight from the classifier definition: w.x + (bias << shift).
  function automatic int model_score(input logic [FW*NF-1:0] f, input logic [WW*NF-1:0] w,
                                     input logic [BW-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < NF; i++) begin
      int wi;
      int xi;
      wi = int'($signed(w[i*WW +: WW]));
      xi = int'(f[i*FW +: FW]);
      s += wi * xi;
    end
    s += int'($signed(b)) <<< BSHIFT;
    return s;
  endfunction

  task automatic capture(input logic [FW*NF-1:0] f, output bit ok);
    int n;
    n = 0;
    while (x_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    ok = (x_ready === 1'b1);
    features = f;
    x_valid = 1'b1;
    cap_cyc = cyc;
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  // Picker side of one round: wait for the strobe, load next pair, answer done.
  task automatic run_round(input bit last, input logic [WW*NF-1:0] nw, input logic [BW-1:0] nb,
                           output int strobe_at, output logic wc, output logic sr_next);
    int n;
    n = 0;
    while (svmready !== 1'b1 && n < 4*ROUND) begin
      @(negedge clk);
      n++;
    end
    strobe_at = (svmready === 1'b1) ? (cyc - cap_cyc) : -1;
    wc = w_class;
    done = last;
    weight = nw;
    bia = nb;
    @(negedge clk);
    done = 1'b0;
    sr_next = svmready;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    x_valid = 1'b0;
    done = 1'b0;
    features = '0;
    weight = '0;
    bia = '0;
    #1;
    checks++; if (x_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_x_ready got %b expected 1", x_ready); end
    checks++; if (svmready !== 1'b0) begin errors++; $display("[TB] FAIL reset_svmready got %b expected 0", svmready); end
    checks++; if (w_class !== 1'b0) begin errors++; $display("[TB] FAIL reset_w_class got %b expected 0", w_class); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_threshold;
    logic [FW*NF-1:0] f;
    logic [WW*NF-1:0] w;
    bit ok;
    int at;
    logic wc, srn, exp;
    f = '0; f[3:0] = 4'd5;
    w = '0; w[7:0] = 8'd3;
    weight = w;
    bia = 12'(-15);
    capture(f, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL thr_capture x_ready got %b expected 1", x_ready); end
    exp = (model_score(f, w, 12'(-15)) >= 0);
    run_round(1'b0, w, 12'(-16), at, wc, srn);
    checks++; if (at !== ROUND) begin errors++; $display("[TB] FAIL thr_strobe_cycle got %0d expected %0d", at, ROUND); end
    checks++; if (wc !== exp) begin errors++; $display("[TB] FAIL thr_score0_w_class got %b expected %b", wc, exp); end
    checks++; if (srn !== 1'b0) begin errors++; $display("[TB] FAIL thr_single_pulse got %b expected 0", srn); end
    exp = (model_score(f, w, 12'(-16)) >= 0);
    run_round(1'b1, w, 12'(-16), at, wc, srn);
    checks++; if (at !== 2*ROUND) begin errors++; $display("[TB] FAIL thr2_strobe_cycle got %0d expected %0d", at, 2*ROUND); end
    checks++; if (wc !== exp) begin errors++; $display("[TB] FAIL thr_neg1_w_class got %b expected %b", wc, exp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL thr_idle_busy got %b expected 0", busy); end
    checks++; if (x_ready !== 1'b0) begin errors++; $display("[TB] FAIL thr_holdoff_x_ready got %b expected 0", x_ready); end
    @(negedge clk);
    checks++; if (x_ready !== 1'b1) begin errors++; $display("[TB] FAIL thr_rearm_x_ready got %b expected 1", x_ready); end
  endtask

  task automatic test_full_scale;
    logic [FW*NF-1:0] f;
    logic [WW*NF-1:0] wpos, wneg;
    bit ok;
    int at;
    logic wc, srn, exp;
    f = {NF{4'hF}};
    wpos = {NF{8'h7F}};
    wneg = {NF{8'h80}};
    weight = wpos;
    bia = '0;
    capture(f, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL fs_capture x_ready got %b expected 1", x_ready); end
    exp = (model_score(f, wpos, '0) >= 0);
    run_round(1'b0, wneg, '0, at, wc, srn);
    checks++; if (wc !== exp) begin errors++; $display("[TB] FAIL fs_pos_w_class got %b expected %b", wc, exp); end
    exp = (model_score(f, wneg, '0) >= 0);
    run_round(1'b1, wneg, '0, at, wc, srn);
    checks++; if (wc !== exp) begin errors++; $display("[TB] FAIL fs_neg_w_class got %b expected %b", wc, exp); end
    checks++; if (at !== 2*ROUND) begin errors++; $display("[TB] FAIL fs_strobe_cycle got %0d expected %0d", at, 2*ROUND); end
  endtask

  task automatic test_cadence;
    logic [WW*NF-1:0] wq [9];
    logic [BW-1:0]    bq [9];
    logic [FW*NF-1:0] f;
    bit ok;
    int at;
    logic wc, srn, exp;
    for (int s = 0; s < 2; s++) begin
      f = {$urandom, $urandom};
      for (int r = 0; r < 9; r++) begin
        wq[r] = {$urandom, $urandom, $urandom, $urandom};
        bq[r] = BW'($urandom);
      end
      weight = wq[0];
      bia = bq[0];
      capture(f, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL cad_capture x_ready got %b expected 1", x_ready); end
      for (int r = 0; r < 9; r++) begin
        exp = (model_score(f, wq[r], bq[r]) >= 0);
        run_round(r == 8, wq[(r < 8) ? r+1 : 8], bq[(r < 8) ? r+1 : 8], at, wc, srn);
        checks++; if (at !== ROUND*(r+1)) begin errors++; $display("[TB] FAIL cad_strobe_cycle r%0d got %0d expected %0d", r, at, ROUND*(r+1)); end
        checks++; if (wc !== exp) begin errors++; $display("[TB] FAIL cad_w_class r%0d got %b expected %b", r, wc, exp); end
        checks++; if (srn !== 1'b0) begin errors++; $display("[TB] FAIL cad_single_pulse r%0d got %b expected 0", r, srn); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cad_idle_busy at %0d got %b expected 0", cyc - cap_cyc, busy); end
      checks++; if (x_ready !== 1'b0) begin errors++; $display("[TB] FAIL cad_holdoff_x_ready got %b expected 0", x_ready); end
      @(negedge clk);
      checks++; if (x_ready !== 1'b1) begin errors++; $display("[TB] FAIL cad_rearm_x_ready got %b expected 1", x_ready); end
    end
  endtask

  task automatic test_guards;
    logic [FW*NF-1:0] fa, fb;
    logic [WW*NF-1:0] w;
    bit ok;
    int at;
    logic wc, srn, exp;
    fa = {NF{4'hF}};
    fb = '0;
    w = {NF{8'h01}};
    weight = w;
    bia = 12'(-100);
    capture(fa, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL grd_capture x_ready got %b expected 1", x_ready); end
    exp = (model_score(fa, w, 12'(-100)) >= 0);
    features = fb;
    x_valid = 1'b1;
    for (int k = 1; k < 16; k++) begin
      done = (k == 3);
      if (k == 5) begin
        checks++; if (x_ready !== 1'b0) begin errors++; $display("[TB] FAIL grd_mac_x_ready got %b expected 0", x_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL grd_mac_busy got %b expected 1", busy); end
      end
      @(negedge clk);
    end
    done = 1'b0;
    x_valid = 1'b0;
    run_round(1'b1, w, 12'(-100), at, wc, srn);
    checks++; if (at !== ROUND) begin errors++; $display("[TB] FAIL grd_strobe_cycle got %0d expected %0d", at, ROUND); end
    checks++; if (wc !== exp) begin errors++; $display("[TB] FAIL grd_no_recapture_w_class got %b expected %b", wc, exp); end
  endtask

  task automatic test_reset_mid_mac;
    logic [FW*NF-1:0] f;
    logic [WW*NF-1:0] w;
    logic [BW-1:0] b;
    bit ok;
    int at;
    logic wc, srn, exp;
    f = {$urandom, $urandom};
    w = {$urandom, $urandom, $urandom, $urandom};
    weight = w;
    bia = '0;
    capture(f, ok);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy got %b expected 0", busy); end
    checks++; if (x_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_x_ready got %b expected 1", x_ready); end
    checks++; if (svmready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_svmready got %b expected 0", svmready); end
    checks++; if (w_class !== 1'b0) begin errors++; $display("[TB] FAIL rmid_w_class got %b expected 0", w_class); end
    @(negedge clk);
    rst_n = 1'b1;
    // Pick a vector whose decision is positive so a stale reset value shows up.
    f = {NF{4'h9}};
    w = {$urandom, $urandom, $urandom, $urandom};
    b = 12'h7FF;
    while (model_score(f, w, b) < 0) w = {$urandom, $urandom, $urandom, $urandom};
    weight = w;
    bia = b;
    exp = (model_score(f, w, b) >= 0);
    capture(f, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_recapture x_ready got %b expected 1", x_ready); end
    run_round(1'b1, w, b, at, wc, srn);
    checks++; if (at !== ROUND) begin errors++; $display("[TB] FAIL rmid_strobe_cycle got %0d expected %0d", at, ROUND); end
    checks++; if (wc !== exp) begin errors++; $display("[TB] FAIL rmid_w_class got %b expected %b", wc, exp); end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_full_scale();
    test_cadence();
    test_guards();
    test_reset_mid_mac();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
